latch_sampler: RTL and testbench
================================

LATCH_SAMPLER -- requirements
Module: latch_sampler

Interface
REQ-001 Parameter WIDTH, default 8, event counter width in bits (legal range 2..16).
REQ-002 Parameter DEBOUNCE, default 4, number of consecutive equal synchronized samples needed to accept a level change (legal range 2..255).
REQ-003 Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 notRst  input  1  asynchronous active-low reset.
REQ-005 LatchQ  input  1  Q output of the upstream d_latch; asynchronous to Clk.
REQ-006 CountEn  input  1  synchronous enable for event counting.
REQ-007 Clear  input  1  synchronous clear of Count and Overflow.
REQ-008 Level  output  1  debounced, synchronized copy of LatchQ.
REQ-009 Rise  output  1  one-cycle pulse when Level goes 0->1.
REQ-010 Fall  output  1  one-cycle pulse when Level goes 1->0.
REQ-011 Count  output  WIDTH  number of accepted rising events, modulo 2^WIDTH.
REQ-012 Overflow  output  1  sticky flag, set when Count wraps.

Function
REQ-013 LatchQ shall pass through a two-flop synchronizer; the second flop output is "s".
REQ-014 The debouncer shall be an FSM with states STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW and an 8-bit run counter "run".
REQ-015 STABLE_LOW: s=1 -> CHECK_HIGH with run=1; otherwise stay, run=0.
REQ-016 CHECK_HIGH: s=0 -> STABLE_LOW with run=0; s=1 and run=DEBOUNCE-1 -> STABLE_HIGH with Level=1 and Rise=1 in the same cycle; otherwise run increments.
REQ-017 STABLE_HIGH and CHECK_LOW shall mirror REQ-015/016 with polarity inverted, asserting Level=0 and Fall=1 on acceptance.
REQ-018 Latency: a LatchQ edge held stable shall update Level exactly 2+DEBOUNCE Clk edges after the first edge that samples the new value.
REQ-019 A glitch on s shorter than DEBOUNCE cycles shall produce no change on Level, Rise or Fall.
REQ-020 Rise and Fall shall be registered, high for exactly one cycle, and never high in the same cycle.
REQ-021 Count shall increment by 1 in the cycle after Rise=1 when CountEn=1.
REQ-022 An increment from 2^WIDTH-1 shall wrap Count to 0 and set Overflow=1; Overflow shall stay 1 until Clear or reset.
REQ-023 Clear=1 shall force Count=0 and Overflow=0 on the next edge and take priority over a simultaneous increment; that event is discarded.
REQ-024 Fall events and CountEn=0 cycles shall never change Count.

Reset
REQ-025 notRst=0 shall immediately force both synchronizer flops to 0, state STABLE_LOW, run=0, Level=0, Rise=0, Fall=0, Count=0, Overflow=0.
REQ-026 Reset asserted mid-CHECK_HIGH/CHECK_LOW shall abandon the pending change without emitting a pulse.
REQ-027 After notRst deasserts with LatchQ=1, Level shall rise per REQ-018, producing one Rise.

Structure
REQ-028 State encodings (2-bit) and default parameter values shall reside in shared package latch_defs_pkg.
REQ-029 The synchronizer shall be a separate sub-module two_flop_sync; debounce FSM and counter shall stay in latch_sampler.

Verification
REQ-030 Reset release, LatchQ=0 for 10 cycles -> Level=0, Count=0, no pulses.
REQ-031 DEBOUNCE=4, LatchQ 0->1 held -> Rise exactly 6 edges later, Level=1, Count=1 the next cycle.
REQ-032 LatchQ high pulse of 3 Clk cycles -> no Rise, Level stays 0, Count unchanged.
REQ-033 WIDTH=2, five accepted rising events with CountEn=1 -> Count sequence 1,2,3,0,1; Overflow=1 from the fourth onward.
REQ-034 Clear asserted in the same cycle the increment would occur -> Count=0, Overflow=0, event not counted.
REQ-035 notRst pulsed low while in CHECK_HIGH (run=2) -> all outputs 0 at once, no Rise emitted before reacceptance.

Source files
------------

// File: rtl/latch_defs_pkg.sv
// rtl/latch_defs_pkg.sv - shared state encodings and default parameters for latch_sampler
package latch_defs_pkg;

    localparam int DEFAULT_WIDTH    = 8;
    localparam int DEFAULT_DEBOUNCE = 4;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        CHECK_HIGH  = 2'b01,
        STABLE_HIGH = 2'b10,
        CHECK_LOW   = 2'b11
    } debState_t;

endpackage

// File: rtl/two_flop_sync.sv
// rtl/two_flop_sync.sv - two-flop synchronizer for a single asynchronous bit
module two_flop_sync (
    input  logic Clk,
    input  logic notRst,
    input  logic D,
    output logic Q
);

    logic meta;

    always_ff @(posedge Clk or negedge notRst) begin
        if (!notRst) begin
            meta <= 1'b0;
            Q    <= 1'b0;
        end else begin
            meta <= D;
            Q    <= meta;
        end
    end

endmodule

// File: rtl/latch_sampler.sv
// rtl/latch_sampler.sv - synchronizes and debounces a d_latch output, emits edge pulses and counts rises
module latch_sampler
    import latch_defs_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEBOUNCE = DEFAULT_DEBOUNCE
) (
    input  logic             Clk,
    input  logic             notRst,
    input  logic             LatchQ,
    input  logic             CountEn,
    input  logic             Clear,
    output logic             Level,
    output logic             Rise,
    output logic             Fall,
    output logic [WIDTH-1:0] Count,
    output logic             Overflow
);

    localparam logic [7:0] RUN_LAST = 8'(DEBOUNCE - 1);

    logic      s;
    debState_t state;
    logic [7:0] run;

    two_flop_sync uSync (
        .Clk    (Clk),
        .notRst (notRst),
        .D      (LatchQ),
        .Q      (s)
    );

    // run counts consecutive samples of the candidate level, the first one included
    always_ff @(posedge Clk or negedge notRst) begin
        if (!notRst) begin
            state <= STABLE_LOW;
            run   <= 8'd0;
            Level <= 1'b0;
            Rise  <= 1'b0;
            Fall  <= 1'b0;
        end else begin
            Rise <= 1'b0;
            Fall <= 1'b0;
            case (state)
                STABLE_LOW: begin
                    if (s) begin
                        state <= CHECK_HIGH;
                        run   <= 8'd1;
                    end else begin
                        run <= 8'd0;
                    end
                end
                CHECK_HIGH: begin
                    if (!s) begin
                        state <= STABLE_LOW;
                        run   <= 8'd0;
                    end else if (run == RUN_LAST) begin
                        state <= STABLE_HIGH;
                        run   <= 8'd0;
                        Level <= 1'b1;
                        Rise  <= 1'b1;
                    end else begin
                        run <= run + 8'd1;
                    end
                end
                STABLE_HIGH: begin
                    if (!s) begin
                        state <= CHECK_LOW;
                        run   <= 8'd1;
                    end else begin
                        run <= 8'd0;
                    end
                end
                CHECK_LOW: begin
                    if (s) begin
                        state <= STABLE_HIGH;
                        run   <= 8'd0;
                    end else if (run == RUN_LAST) begin
                        state <= STABLE_LOW;
                        run   <= 8'd0;
                        Level <= 1'b0;
                        Fall  <= 1'b1;
                    end else begin
                        run <= run + 8'd1;
                    end
                end
            endcase
        end
    end

    // Clear wins over a coincident increment, so that rising event is lost
    always_ff @(posedge Clk or negedge notRst) begin
        if (!notRst) begin
            Count    <= '0;
            Overflow <= 1'b0;
        end else if (Clear) begin
            Count    <= '0;
            Overflow <= 1'b0;
        end else if (Rise && CountEn) begin
            Count <= Count + WIDTH'(1);
            if (Count == '1) begin
                Overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_latch_sampler.sv
// tb/tb_latch_sampler.sv - directed self-checking bench for latch_sampler (WIDTH=2, DEBOUNCE=4)
module tb_latch_sampler;

    logic       Clk     = 1'b0;
    logic       notRst  = 1'b0;
    logic       LatchQ  = 1'b0;
    logic       CountEn = 1'b1;
    logic       Clear   = 1'b0;
    logic       Level;
    logic       Rise;
    logic       Fall;
    logic [1:0] Count;
    logic       Overflow;

    int checkCount = 0;
    int passCount  = 0;
    int riseSeen   = 0;
    int fallSeen   = 0;
    int bothSeen   = 0;

    logic [1:0] wrapExp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    always #5 Clk = ~Clk;

    latch_sampler #(.WIDTH(2), .DEBOUNCE(4)) dut (
        .Clk      (Clk),
        .notRst   (notRst),
        .LatchQ   (LatchQ),
        .CountEn  (CountEn),
        .Clear    (Clear),
        .Level    (Level),
        .Rise     (Rise),
        .Fall     (Fall),
        .Count    (Count),
        .Overflow (Overflow)
    );

    always @(negedge Clk) begin
        if (Rise) riseSeen++;
        if (Fall) fallSeen++;
        if (Rise && Fall) bothSeen++;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            passCount++;
    endtask

    task automatic pulseEvent();
        LatchQ = 1'b1;
        repeat (7) step();
        LatchQ = 1'b0;
        repeat (7) step();
    endtask

    initial begin
        int riseBase;

        repeat (2) step();
        checkVal("rst_level", Level, 0);
        checkVal("rst_rise", Rise, 0);
        checkVal("rst_fall", Fall, 0);
        checkVal("rst_count", Count, 0);
        checkVal("rst_ovf", Overflow, 0);

        notRst = 1'b1;
        repeat (10) step();
        checkVal("idle_level", Level, 0);
        checkVal("idle_count", Count, 0);
        checkVal("idle_pulses", riseSeen + fallSeen, 0);

        LatchQ = 1'b1;
        repeat (5) step();
        checkVal("rise_early_level", Level, 0);
        checkVal("rise_early_pulse", Rise, 0);
        step();
        checkVal("rise_level", Level, 1);
        checkVal("rise_pulse", Rise, 1);
        step();
        checkVal("rise_one_cycle", Rise, 0);
        checkVal("rise_count", Count, 1);

        LatchQ = 1'b0;
        repeat (5) step();
        checkVal("fall_early_level", Level, 1);
        step();
        checkVal("fall_level", Level, 0);
        checkVal("fall_pulse", Fall, 1);
        step();
        checkVal("fall_one_cycle", Fall, 0);
        checkVal("fall_no_count", Count, 1);

        riseBase = riseSeen;
        LatchQ = 1'b1;
        repeat (3) step();
        LatchQ = 1'b0;
        repeat (10) step();
        checkVal("glitch_level", Level, 0);
        checkVal("glitch_rise", riseSeen - riseBase, 0);
        checkVal("glitch_count", Count, 1);

        Clear = 1'b1;
        step();
        Clear = 1'b0;
        checkVal("clear_count", Count, 0);
        checkVal("clear_ovf", Overflow, 0);

        for (int i = 0; i < 5; i++) begin
            pulseEvent();
            checkVal($sformatf("wrap_count%0d", i + 1), Count, wrapExp[i]);
            checkVal($sformatf("wrap_ovf%0d", i + 1), Overflow, (i >= 3) ? 1 : 0);
        end

        CountEn = 1'b0;
        pulseEvent();
        CountEn = 1'b1;
        checkVal("disabled_count", Count, 1);
        checkVal("disabled_ovf", Overflow, 1);

        LatchQ = 1'b1;
        repeat (6) step();
        checkVal("clr_rise", Rise, 1);
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        checkVal("clr_count", Count, 0);
        checkVal("clr_ovf", Overflow, 0);
        repeat (3) step();
        checkVal("clr_discard", Count, 0);
        LatchQ = 1'b0;
        repeat (7) step();

        pulseEvent();
        checkVal("pre_reset_count", Count, 1);

        riseBase = riseSeen;
        LatchQ = 1'b1;
        repeat (4) step();
        notRst = 1'b0;
        #1;
        checkVal("rstmid_level", Level, 0);
        checkVal("rstmid_rise", Rise, 0);
        checkVal("rstmid_fall", Fall, 0);
        checkVal("rstmid_count", Count, 0);
        checkVal("rstmid_ovf", Overflow, 0);
        repeat (2) step();
        notRst = 1'b1;
        repeat (5) step();
        checkVal("rstmid_early_level", Level, 0);
        checkVal("rstmid_no_rise", riseSeen - riseBase, 0);
        step();
        checkVal("rstmid_reaccept_level", Level, 1);
        checkVal("rstmid_reaccept_rise", Rise, 1);
        step();
        checkVal("rstmid_count_after", Count, 1);
        checkVal("rstmid_one_rise", riseSeen - riseBase, 1);

        checkVal("never_both", bothSeen, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
